// File: rtl/axi_default_slave_0.sv
// AXI4 default slave: completes unmapped writes and reads with DECERR.
// Optional error counters enabled by defining AXI_DEFAULT_SLAVE_ERR_CNT_EN.
module axi_default_slave_0 #(
    parameter int                      PARAM_WIDTH = 32,
    parameter logic [PARAM_WIDTH-1:0]  ID_WIDTH    = 4,
    parameter logic [PARAM_WIDTH-1:0]  DATA_WIDTH  = 32,
    parameter logic [1:0]              RESP_DECERR = 2'b11
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ID_WIDTH-1:0]   awid,
    input  logic [7:0]            awlen,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [ID_WIDTH-1:0]   bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [7:0]            arlen,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
`ifdef AXI_DEFAULT_SLAVE_ERR_CNT_EN
    input  logic                  rready,
    input  logic                  err_cnt_clr,
    output logic [15:0]           err_wr_cnt,
    output logic [15:0]           err_rd_cnt
`else
    input  logic                  rready
`endif
);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA} rstate_t;

    wstate_t              r_wstate;
    wstate_t              w_wnext;
    rstate_t              r_rstate;
    rstate_t              w_rnext;

    logic                 r_awready;
    logic                 r_wready;
    logic                 r_bvalid;
    logic [ID_WIDTH-1:0]  r_bid;
    logic                 r_arready;
    logic                 r_rvalid;
    logic                 r_rlast;
    logic [ID_WIDTH-1:0]  r_rid;
    logic [7:0]           r_cnt;

    logic                 w_aw_hs;
    logic                 w_w_hs;
    logic                 w_b_hs;
    logic                 w_ar_hs;
    logic                 w_r_hs;
    logic                 w_unused_awlen;

    // Writes finish on wlast, so the burst length carries no information here.
    assign w_unused_awlen = ^awlen;

    assign w_aw_hs = awvalid & r_awready;
    assign w_w_hs  = wvalid & r_wready & wlast;
    assign w_b_hs  = r_bvalid & bready;
    assign w_ar_hs = arvalid & r_arready;
    assign w_r_hs  = r_rvalid & rready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wnext;
        end
    end

    always_comb begin
        w_wnext = r_wstate;
        unique case (r_wstate)
            W_IDLE:  if (w_aw_hs) w_wnext = W_DATA;
            W_DATA:  if (w_w_hs)  w_wnext = W_RESP;
            W_RESP:  if (w_b_hs)  w_wnext = W_IDLE;
            default: w_wnext = W_IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the next-state decode.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= '0;
        end else begin
            r_awready <= (w_wnext == W_IDLE);
            r_wready  <= (w_wnext == W_DATA);
            r_bvalid  <= (w_wnext == W_RESP);
            if (w_aw_hs) r_bid <= awid;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rnext;
        end
    end

    always_comb begin
        w_rnext = r_rstate;
        unique case (r_rstate)
            R_IDLE:  if (w_ar_hs)           w_rnext = R_DATA;
            R_DATA:  if (w_r_hs && r_rlast) w_rnext = R_IDLE;
            default: w_rnext = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rid     <= '0;
            r_cnt     <= 8'd0;
        end else begin
            r_arready <= (w_rnext == R_IDLE);
            r_rvalid  <= (w_rnext == R_DATA);
            if (w_ar_hs) begin
                r_rid   <= arid;
                r_cnt   <= arlen;
                r_rlast <= (arlen == 8'd0);
            end else if (w_r_hs) begin
                // The last beat leaves with the counter at zero: no wrap.
                if (r_rlast) begin
                    r_rlast <= 1'b0;
                end else begin
                    r_cnt   <= r_cnt - 8'd1;
                    r_rlast <= (r_cnt == 8'd1);
                end
            end
        end
    end

    assign awready = r_awready;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bid     = r_bid;
    assign bresp   = RESP_DECERR;
    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rlast   = r_rlast;
    assign rid     = r_rid;
    assign rdata   = '0;
    assign rresp   = RESP_DECERR;

`ifdef AXI_DEFAULT_SLAVE_ERR_CNT_EN
    logic [15:0] r_err_wr_cnt;
    logic [15:0] r_err_rd_cnt;

    always_ff @(posedge aclk) begin
        if (!aresetn || err_cnt_clr) begin
            r_err_wr_cnt <= 16'd0;
            r_err_rd_cnt <= 16'd0;
        end else begin
            if (w_b_hs && r_err_wr_cnt != 16'hFFFF)
                r_err_wr_cnt <= r_err_wr_cnt + 16'd1;
            if (w_r_hs && r_rlast && r_err_rd_cnt != 16'hFFFF)
                r_err_rd_cnt <= r_err_rd_cnt + 16'd1;
        end
    end

    assign err_wr_cnt = r_err_wr_cnt;
    assign err_rd_cnt = r_err_rd_cnt;
`endif

endmodule

// File: tb/tb_axi_default_slave_0.sv
// Directed self-checking bench for axi_default_slave_0.
// Counter checks run when AXI_DEFAULT_SLAVE_ERR_CNT_EN is defined.
module tb_axi_default_slave_0;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic        awvalid;
    logic        awready;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
`ifdef AXI_DEFAULT_SLAVE_ERR_CNT_EN
    logic        err_cnt_clr;
    logic [15:0] err_wr_cnt;
    logic [15:0] err_rd_cnt;
`endif

    int pass_cnt = 0;
    int total    = 0;

    always #5 aclk = ~aclk;

    axi_default_slave_0 dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .awid        (awid),
        .awlen       (awlen),
        .awvalid     (awvalid),
        .awready     (awready),
        .wlast       (wlast),
        .wvalid      (wvalid),
        .wready      (wready),
        .bid         (bid),
        .bresp       (bresp),
        .bvalid      (bvalid),
        .bready      (bready),
        .arid        (arid),
        .arlen       (arlen),
        .arvalid     (arvalid),
        .arready     (arready),
        .rid         (rid),
        .rdata       (rdata),
        .rresp       (rresp),
        .rlast       (rlast),
        .rvalid      (rvalid),
`ifdef AXI_DEFAULT_SLAVE_ERR_CNT_EN
        .rready      (rready),
        .err_cnt_clr (err_cnt_clr),
        .err_wr_cnt  (err_wr_cnt),
        .err_rd_cnt  (err_rd_cnt)
`else
        .rready      (rready)
`endif
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        tick();
        tick();
        total++; if (awready !== 1'b0) $display("FAIL rst_awready got %0h exp 0", awready); else pass_cnt++;
        total++; if (arready !== 1'b0) $display("FAIL rst_arready got %0h exp 0", arready); else pass_cnt++;
        total++; if (wready !== 1'b0) $display("FAIL rst_wready got %0h exp 0", wready); else pass_cnt++;
        total++; if (bvalid !== 1'b0) $display("FAIL rst_bvalid got %0h exp 0", bvalid); else pass_cnt++;
        total++; if (rvalid !== 1'b0) $display("FAIL rst_rvalid got %0h exp 0", rvalid); else pass_cnt++;
        total++; if (rlast !== 1'b0) $display("FAIL rst_rlast got %0h exp 0", rlast); else pass_cnt++;
        total++; if (bid !== 4'h0) $display("FAIL rst_bid got %0h exp 0", bid); else pass_cnt++;
        total++; if (rid !== 4'h0) $display("FAIL rst_rid got %0h exp 0", rid); else pass_cnt++;
        aresetn = 1'b1;
        tick();
        total++; if (awready !== 1'b1) $display("FAIL rel_awready got %0h exp 1", awready); else pass_cnt++;
        total++; if (arready !== 1'b1) $display("FAIL rel_arready got %0h exp 1", arready); else pass_cnt++;
        total++; if (wready !== 1'b0) $display("FAIL rel_wready got %0h exp 0", wready); else pass_cnt++;
    endtask

    task automatic test_single_write();
        awid = 4'h5;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        total++; if (awready !== 1'b0) $display("FAIL wr_awready_drop got %0h exp 0", awready); else pass_cnt++;
        total++; if (wready !== 1'b1) $display("FAIL wr_wready got %0h exp 1", wready); else pass_cnt++;
        wvalid = 1'b1;
        wlast = 1'b1;
        bready = 1'b1;
        tick();
        wvalid = 1'b0;
        wlast = 1'b0;
        total++; if (wready !== 1'b0) $display("FAIL wr_wready_drop got %0h exp 0", wready); else pass_cnt++;
        total++; if (bvalid !== 1'b1) $display("FAIL wr_bvalid got %0h exp 1", bvalid); else pass_cnt++;
        total++; if (bid !== 4'h5) $display("FAIL wr_bid got %0h exp 5", bid); else pass_cnt++;
        total++; if (bresp !== 2'b11) $display("FAIL wr_bresp got %0h exp 3", bresp); else pass_cnt++;
        tick();
        bready = 1'b0;
        total++; if (bvalid !== 1'b0) $display("FAIL wr_bvalid_drop got %0h exp 0", bvalid); else pass_cnt++;
        total++; if (awready !== 1'b1) $display("FAIL wr_awready_back got %0h exp 1", awready); else pass_cnt++;
    endtask

    task automatic test_burst_read();
        arid = 4'hA;
        arlen = 8'd3;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        rready = 1'b1;
        total++; if (arready !== 1'b0) $display("FAIL rd_arready_drop got %0h exp 0", arready); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total++; if (rvalid !== 1'b1) $display("FAIL rd_rvalid beat %0d got %0h exp 1", i, rvalid); else pass_cnt++;
            total++; if (rlast !== (i == 3)) $display("FAIL rd_rlast beat %0d got %0h exp %0h", i, rlast, (i == 3)); else pass_cnt++;
            total++; if (rid !== 4'hA) $display("FAIL rd_rid beat %0d got %0h exp a", i, rid); else pass_cnt++;
            total++; if (rdata !== 32'h0) $display("FAIL rd_rdata beat %0d got %0h exp 0", i, rdata); else pass_cnt++;
            total++; if (rresp !== 2'b11) $display("FAIL rd_rresp beat %0d got %0h exp 3", i, rresp); else pass_cnt++;
            tick();
        end
        rready = 1'b0;
        total++; if (rvalid !== 1'b0) $display("FAIL rd_rvalid_end got %0h exp 0", rvalid); else pass_cnt++;
        total++; if (arready !== 1'b1) $display("FAIL rd_arready_back got %0h exp 1", arready); else pass_cnt++;
    endtask

    task automatic test_read_stall();
        arid = 4'h6;
        arlen = 8'd0;
        arvalid = 1'b1;
        rready = 1'b0;
        tick();
        arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++; if (rvalid !== 1'b1) $display("FAIL stall_rvalid cyc %0d got %0h exp 1", i, rvalid); else pass_cnt++;
            total++; if (rlast !== 1'b1) $display("FAIL stall_rlast cyc %0d got %0h exp 1", i, rlast); else pass_cnt++;
            total++; if (rid !== 4'h6) $display("FAIL stall_rid cyc %0d got %0h exp 6", i, rid); else pass_cnt++;
            tick();
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        total++; if (rvalid !== 1'b0) $display("FAIL stall_done got %0h exp 0", rvalid); else pass_cnt++;
        total++; if (arready !== 1'b1) $display("FAIL stall_arready got %0h exp 1", arready); else pass_cnt++;
    endtask

    task automatic test_w_before_aw();
        wvalid = 1'b1;
        wlast = 1'b1;
        arid = 4'h3;
        arlen = 8'd1;
        arvalid = 1'b1;
        rready = 1'b1;
        tick();
        arvalid = 1'b0;
        total++; if (wready !== 1'b0) $display("FAIL early_w_wready0 got %0h exp 0", wready); else pass_cnt++;
        total++; if (rvalid !== 1'b1) $display("FAIL early_w_rvalid got %0h exp 1", rvalid); else pass_cnt++;
        tick();
        total++; if (wready !== 1'b0) $display("FAIL early_w_wready1 got %0h exp 0", wready); else pass_cnt++;
        total++; if (rlast !== 1'b1) $display("FAIL early_w_rlast got %0h exp 1", rlast); else pass_cnt++;
        total++; if (rresp !== 2'b11) $display("FAIL early_w_rresp got %0h exp 3", rresp); else pass_cnt++;
        total++; if (rid !== 4'h3) $display("FAIL early_w_rid got %0h exp 3", rid); else pass_cnt++;
        tick();
        rready = 1'b0;
        total++; if (rvalid !== 1'b0) $display("FAIL early_w_rdone got %0h exp 0", rvalid); else pass_cnt++;
        total++; if (bvalid !== 1'b0) $display("FAIL early_w_nob got %0h exp 0", bvalid); else pass_cnt++;
        awid = 4'hC;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        total++; if (wready !== 1'b1) $display("FAIL early_w_wready_up got %0h exp 1", wready); else pass_cnt++;
        tick();
        wvalid = 1'b0;
        wlast = 1'b0;
        total++; if (bvalid !== 1'b1) $display("FAIL early_w_bvalid got %0h exp 1", bvalid); else pass_cnt++;
        total++; if (bid !== 4'hC) $display("FAIL early_w_bid got %0h exp c", bid); else pass_cnt++;
        total++; if (bresp !== 2'b11) $display("FAIL early_w_bresp got %0h exp 3", bresp); else pass_cnt++;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        total++; if (bvalid !== 1'b0) $display("FAIL early_w_bdone got %0h exp 0", bvalid); else pass_cnt++;
        total++; if (awready !== 1'b1) $display("FAIL early_w_awready got %0h exp 1", awready); else pass_cnt++;
    endtask

    task automatic test_reset_midburst();
        arid = 4'h9;
        arlen = 8'd7;
        arvalid = 1'b1;
        rready = 1'b1;
        tick();
        arvalid = 1'b0;
        tick();
        aresetn = 1'b0;
        tick();
        total++; if (rvalid !== 1'b0) $display("FAIL midrst_rvalid got %0h exp 0", rvalid); else pass_cnt++;
        total++; if (arready !== 1'b0) $display("FAIL midrst_arready got %0h exp 0", arready); else pass_cnt++;
        total++; if (rlast !== 1'b0) $display("FAIL midrst_rlast got %0h exp 0", rlast); else pass_cnt++;
        aresetn = 1'b1;
        tick();
        total++; if (arready !== 1'b1) $display("FAIL midrst_arready_up got %0h exp 1", arready); else pass_cnt++;
        total++; if (rvalid !== 1'b0) $display("FAIL midrst_noresume got %0h exp 0", rvalid); else pass_cnt++;
        arid = 4'h2;
        arlen = 8'd0;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        total++; if (rvalid !== 1'b1 || rlast !== 1'b1) $display("FAIL midrst_beat got %0h%0h exp 11", rvalid, rlast); else pass_cnt++;
        total++; if (rid !== 4'h2) $display("FAIL midrst_rid got %0h exp 2", rid); else pass_cnt++;
        tick();
        rready = 1'b0;
        total++; if (rvalid !== 1'b0) $display("FAIL midrst_onebeat got %0h exp 0", rvalid); else pass_cnt++;
    endtask

    task automatic test_long_read();
        int beats = 0;
        int lasts = 0;
        int last_at = 0;
        arid = 4'hF;
        arlen = 8'd255;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        rready = 1'b1;
        for (int i = 0; i < 300 && rvalid; i++) begin
            beats++;
            if (rlast) begin
                lasts++;
                last_at = beats;
            end
            tick();
        end
        rready = 1'b0;
        total++; if (rvalid !== 1'b0) $display("FAIL long_timeout rvalid %0h exp 0", rvalid); else pass_cnt++;
        total++; if (beats != 256) $display("FAIL long_beats got %0d exp 256", beats); else pass_cnt++;
        total++; if (lasts != 1 || last_at != 256) $display("FAIL long_rlast got %0d at %0d exp 1 at 256", lasts, last_at); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        awid = 4'h1;
        awvalid = 1'b1;
        arid = 4'h4;
        arlen = 8'd0;
        arvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        arvalid = 1'b0;
        total++; if (wready !== 1'b1) $display("FAIL b2b_wready got %0h exp 1", wready); else pass_cnt++;
        total++; if (rvalid !== 1'b1 || rid !== 4'h4) $display("FAIL b2b_r got %0h/%0h exp 1/4", rvalid, rid); else pass_cnt++;
        wvalid = 1'b1;
        wlast = 1'b1;
        rready = 1'b1;
        tick();
        wvalid = 1'b0;
        wlast = 1'b0;
        rready = 1'b0;
        total++; if (bvalid !== 1'b1 || bid !== 4'h1) $display("FAIL b2b_b got %0h/%0h exp 1/1", bvalid, bid); else pass_cnt++;
        total++; if (arready !== 1'b1 || awready !== 1'b0) $display("FAIL b2b_rdy got ar%0h aw%0h exp ar1 aw0", arready, awready); else pass_cnt++;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        total++; if (awready !== 1'b1) $display("FAIL b2b_awready got %0h exp 1", awready); else pass_cnt++;
    endtask

`ifdef AXI_DEFAULT_SLAVE_ERR_CNT_EN
    task automatic do_write();
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid = 1'b1;
        wlast = 1'b1;
        tick();
        wvalid = 1'b0;
        wlast = 1'b0;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] len);
        arlen = len;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        rready = 1'b1;
        repeat (int'(len) + 1) tick();
        rready = 1'b0;
    endtask

    task automatic test_err_cnt();
        err_cnt_clr = 1'b1;
        tick();
        err_cnt_clr = 1'b0;
        total++; if (err_wr_cnt !== 16'd0 || err_rd_cnt !== 16'd0) $display("FAIL cnt_clr got %0d/%0d exp 0/0", err_wr_cnt, err_rd_cnt); else pass_cnt++;
        do_write();
        do_write();
        do_write();
        do_read(8'd2);
        do_read(8'd0);
        total++; if (err_wr_cnt !== 16'd3) $display("FAIL cnt_wr got %0d exp 3", err_wr_cnt); else pass_cnt++;
        total++; if (err_rd_cnt !== 16'd2) $display("FAIL cnt_rd got %0d exp 2", err_rd_cnt); else pass_cnt++;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid = 1'b1;
        wlast = 1'b1;
        tick();
        wvalid = 1'b0;
        wlast = 1'b0;
        bready = 1'b1;
        err_cnt_clr = 1'b1;
        tick();
        bready = 1'b0;
        err_cnt_clr = 1'b0;
        total++; if (err_wr_cnt !== 16'd0 || err_rd_cnt !== 16'd0) $display("FAIL cnt_clr_prio got %0d/%0d exp 0/0", err_wr_cnt, err_rd_cnt); else pass_cnt++;
    endtask
`endif

    initial begin
        aresetn = 1'b0;
        awid = '0;
        awlen = 8'd0;
        awvalid = 1'b0;
        wlast = 1'b0;
        wvalid = 1'b0;
        bready = 1'b0;
        arid = '0;
        arlen = 8'd0;
        arvalid = 1'b0;
        rready = 1'b0;
`ifdef AXI_DEFAULT_SLAVE_ERR_CNT_EN
        err_cnt_clr = 1'b0;
`endif
        #2;
        test_reset();
        test_single_write();
        test_burst_read();
        test_read_stall();
        test_w_before_aw();
        test_reset_midburst();
        test_long_read();
        test_back_to_back();
`ifdef AXI_DEFAULT_SLAVE_ERR_CNT_EN
        test_err_cnt();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
